// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter for the shared serial data bus.
// Selects a master whose target slave is idle, serializes the slave ID on
// arbiter_cmd_out (start bit, then ID MSB first), grants the bus and
// supervises it through bus_util until release.
// Optional GRANT watchdog enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int MASTER_COUNT   = 3,
  parameter int SLAVE_COUNT    = 3,
  parameter int ID_WIDTH       = 3,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [MASTER_COUNT-1:0]          mreq,
  input  logic [MASTER_COUNT*ID_WIDTH-1:0] mslave_id,
  input  logic [SLAVE_COUNT-1:0]           slave_busy,
  input  logic                             bus_util,
  output logic [MASTER_COUNT-1:0]          mgrant,
  output logic                             arbiter_cmd_out,
  output logic [1:0]                       cur_master,
  output logic                             bus_granted,
  output logic                             timeout_err
);

  localparam int CNT_W = $clog2(ID_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                            r_state;
  logic [ID_WIDTH-1:0]               r_id_sh;
  logic [CNT_W-1:0]                  r_bit_cnt;
  logic                              r_seen_util;

  logic [MASTER_COUNT-1:0]           w_elig;
  logic [MASTER_COUNT*ID_WIDTH-1:0]  w_id_sh;
  logic [SLAVE_COUNT-1:0]            w_busy_sh;
  logic [MASTER_COUNT-1:0]           w_req_sh;
  logic [MASTER_COUNT-1:0]           w_elig_sh;
  logic                              w_ok;
  logic                              w_found;
  logic [1:0]                        w_win;
  logic [31:0]                       w_cur32;
  logic [MASTER_COUNT*ID_WIDTH-1:0]  w_win_id_sh;
  logic [MASTER_COUNT-1:0]           w_cur_req_sh;
  logic                              w_cur_req;
  logic [MASTER_COUNT-1:0]           w_cur_onehot;
  logic                              w_release;

  // Eligibility per master: requesting, valid slave ID, slave not busy
  always_comb begin
    w_elig    = '0;
    w_id_sh   = '0;
    w_busy_sh = '0;
    w_req_sh  = '0;
    w_ok      = 1'b0;
    for (int unsigned i = 0; i < MASTER_COUNT; i++) begin
      w_id_sh  = mslave_id >> (i * ID_WIDTH);
      w_req_sh = mreq >> i;
      w_ok     = 1'b0;
      for (int unsigned j = 0; j < SLAVE_COUNT; j++) begin
        w_busy_sh = slave_busy >> j;
        if (w_id_sh[ID_WIDTH-1:0] == ID_WIDTH'(j) && !w_busy_sh[0]) begin
          w_ok = 1'b1;
        end
      end
      if (w_req_sh[0] && w_ok) begin
        w_elig = w_elig | (MASTER_COUNT'(1) << i);
      end
    end
  end

  // Round-robin search starting one past the last winner
  always_comb begin
    w_found   = 1'b0;
    w_win     = '0;
    w_elig_sh = '0;
    w_cur32   = {30'd0, cur_master};
    for (int unsigned k = 1; k <= MASTER_COUNT; k++) begin
      w_elig_sh = w_elig >> ((w_cur32 + k) % MASTER_COUNT);
      if (!w_found && w_elig_sh[0]) begin
        w_found = 1'b1;
        w_win   = 2'((w_cur32 + k) % MASTER_COUNT);
      end
    end
  end

  // Current owner helpers and normal release condition
  always_comb begin
    w_win_id_sh  = mslave_id >> (w_win * ID_WIDTH);
    w_cur_req_sh = mreq >> cur_master;
    w_cur_req    = w_cur_req_sh[0];
    w_cur_onehot = MASTER_COUNT'(1) << cur_master;
    w_release    = !bus_util && (r_seen_util || !w_cur_req);
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0] r_to_cnt;
  logic [7:0] w_to_next;

  // Next watchdog count
  always_comb begin
    w_to_next = r_to_cnt + 8'd1;
  end
`else
  logic w_unused_timeout;

  // No watchdog: GRANT waits indefinitely
  always_comb begin
    w_unused_timeout = ^(8'(TIMEOUT_CYCLES));
  end

  assign timeout_err = 1'b0;
`endif

  // Arbiter FSM with registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state         <= IDLE;
      r_id_sh         <= '0;
      r_bit_cnt       <= '0;
      r_seen_util     <= 1'b0;
      mgrant          <= '0;
      arbiter_cmd_out <= 1'b0;
      cur_master      <= 2'(MASTER_COUNT - 1);
      bus_granted     <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      r_to_cnt        <= '0;
      timeout_err     <= 1'b0;
`endif
    end else begin
`ifdef BUS_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          mgrant          <= '0;
          arbiter_cmd_out <= 1'b0;
          if (w_found) begin
            r_state         <= CMD;
            cur_master      <= w_win;
            r_id_sh         <= w_win_id_sh[ID_WIDTH-1:0];
            r_bit_cnt       <= '0;
            arbiter_cmd_out <= 1'b1;
            bus_granted     <= 1'b1;
          end else begin
            bus_granted     <= 1'b0;
          end
        end
        CMD: begin
          // The shift register presents the ID MSB first after the start bit
          if (r_bit_cnt == CNT_W'(ID_WIDTH)) begin
            r_state         <= GRANT;
            r_bit_cnt       <= '0;
            arbiter_cmd_out <= 1'b0;
            mgrant          <= w_cur_onehot;
            r_seen_util     <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            r_to_cnt        <= '0;
`endif
          end else begin
            arbiter_cmd_out <= r_id_sh[ID_WIDTH-1];
            r_id_sh         <= r_id_sh << 1;
            r_bit_cnt       <= r_bit_cnt + CNT_W'(1);
          end
        end
        GRANT: begin
          if (bus_util) begin
            r_seen_util <= 1'b1;
          end
          if (w_release) begin
            r_state <= RELEASE;
            mgrant  <= '0;
          end
`ifdef BUS_ARB_TIMEOUT_EN
          else if (!r_seen_util && !bus_util) begin
            if (w_to_next == 8'(TIMEOUT_CYCLES)) begin
              r_state     <= RELEASE;
              mgrant      <= '0;
              timeout_err <= 1'b1;
            end
            r_to_cnt <= w_to_next;
          end
`endif
        end
        RELEASE: begin
          r_state     <= IDLE;
          mgrant      <= '0;
          bus_granted <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          mgrant      <= '0;
          bus_granted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter (default parameters, TIMEOUT_CYCLES=10).
module tb_bus_arbiter;

  logic       clk;
  logic       rstn;
  logic [2:0] mreq;
  logic [8:0] mslave_id;
  logic [2:0] slave_busy;
  logic       bus_util;
  logic [2:0] mgrant;
  logic       arbiter_cmd_out;
  logic [1:0] cur_master;
  logic       bus_granted;
  logic       timeout_err;

  int checks   = 0;
  int failures = 0;

  bus_arbiter #(
    .MASTER_COUNT  (3),
    .SLAVE_COUNT   (3),
    .ID_WIDTH      (3),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .mreq           (mreq),
    .mslave_id      (mslave_id),
    .slave_busy     (slave_busy),
    .bus_util       (bus_util),
    .mgrant         (mgrant),
    .arbiter_cmd_out(arbiter_cmd_out),
    .cur_master     (cur_master),
    .bus_granted    (bus_granted),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rstn       = 1'b0;
    mreq       = '0;
    mslave_id  = '0;
    slave_busy = '0;
    bus_util   = 1'b0;
    tick(2);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (mgrant !== 3'b000) begin
      failures++; $display("FAIL reset_mgrant got=%b exp=%b", mgrant, 3'b000);
    end
    checks++;
    if (arbiter_cmd_out !== 1'b0) begin
      failures++; $display("FAIL reset_cmd got=%b exp=0", arbiter_cmd_out);
    end
    checks++;
    if (cur_master !== 2'd2) begin
      failures++; $display("FAIL reset_cur_master got=%0d exp=2", cur_master);
    end
    checks++;
    if (bus_granted !== 1'b0) begin
      failures++; $display("FAIL reset_bus_granted got=%b exp=0", bus_granted);
    end
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err);
    end
  endtask

  task automatic test_single();
    logic [3:0] exp_seq;
    exp_seq = 4'b1010;
    do_reset();
    mslave_id = 9'b000_000_010;
    mreq      = 3'b001;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checks++;
      if (arbiter_cmd_out !== exp_seq[3-i]) begin
        failures++;
        $display("FAIL single_cmd_bit%0d got=%b exp=%b", i, arbiter_cmd_out, exp_seq[3-i]);
      end
      checks++;
      if (mgrant !== 3'b000 || bus_granted !== 1'b1) begin
        failures++;
        $display("FAIL single_cmd_state%0d got mgrant=%b bus_granted=%b exp 000/1", i, mgrant, bus_granted);
      end
    end
    tick(1);
    checks++;
    if (mgrant !== 3'b001 || arbiter_cmd_out !== 1'b0 || cur_master !== 2'd0) begin
      failures++;
      $display("FAIL single_grant got mgrant=%b cmd=%b cur=%0d exp 001/0/0", mgrant, arbiter_cmd_out, cur_master);
    end
    bus_util = 1'b1;
    tick(5);
    checks++;
    if (mgrant !== 3'b001) begin
      failures++; $display("FAIL single_hold got=%b exp=001", mgrant);
    end
    bus_util = 1'b0;
    tick(1);
    checks++;
    if (mgrant !== 3'b000 || bus_granted !== 1'b1) begin
      failures++;
      $display("FAIL single_release got mgrant=%b bus_granted=%b exp 000/1", mgrant, bus_granted);
    end
    mreq = 3'b000;
    tick(1);
    checks++;
    if (bus_granted !== 1'b0) begin
      failures++; $display("FAIL single_idle got=%b exp=0", bus_granted);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g;
    do_reset();
    mslave_id = 9'b000_000_000;
    mreq      = 3'b111;
    tick(5);
    for (int o = 0; o < 4; o++) begin
      exp_g = 3'b001 << (o % 3);
      checks++;
      if (mgrant !== exp_g) begin
        failures++; $display("FAIL rr_grant%0d got=%b exp=%b", o, mgrant, exp_g);
      end
      if (o < 3) begin
        bus_util = 1'b1;
        tick(3);
        bus_util = 1'b0;
        tick(1);
        checks++;
        if (mgrant !== 3'b000) begin
          failures++; $display("FAIL rr_dead%0d got=%b exp=000", o, mgrant);
        end
        tick(5);
        checks++;
        if (mgrant !== 3'b000) begin
          failures++; $display("FAIL rr_gap%0d got=%b exp=000", o, mgrant);
        end
        tick(1);
      end
    end
  endtask

  task automatic test_busy_skip();
    do_reset();
    mslave_id  = {3'd0, 3'd0, 3'd1};
    slave_busy = 3'b010;
    mreq       = 3'b011;
    tick(5);
    checks++;
    if (mgrant !== 3'b010 || cur_master !== 2'd1) begin
      failures++; $display("FAIL busy_skip got mgrant=%b cur=%0d exp 010/1", mgrant, cur_master);
    end
    slave_busy = 3'b000;
    mreq       = 3'b001;
    tick(1);
    checks++;
    if (mgrant !== 3'b000) begin
      failures++; $display("FAIL busy_release got=%b exp=000", mgrant);
    end
    tick(6);
    checks++;
    if (mgrant !== 3'b001 || cur_master !== 2'd0) begin
      failures++; $display("FAIL busy_cleared got mgrant=%b cur=%0d exp 001/0", mgrant, cur_master);
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    mslave_id = 9'b000_000_001;
    mreq      = 3'b001;
    tick(3);
    mreq = 3'b000;
    tick(1);
    checks++;
    if (arbiter_cmd_out !== 1'b1) begin
      failures++; $display("FAIL withdraw_frame got=%b exp=1", arbiter_cmd_out);
    end
    tick(1);
    checks++;
    if (mgrant !== 3'b001) begin
      failures++; $display("FAIL withdraw_grant got=%b exp=001", mgrant);
    end
    tick(1);
    checks++;
    if (mgrant !== 3'b000 || bus_granted !== 1'b1) begin
      failures++;
      $display("FAIL withdraw_release got mgrant=%b bus_granted=%b exp 000/1", mgrant, bus_granted);
    end
    tick(1);
    checks++;
    if (bus_granted !== 1'b0) begin
      failures++; $display("FAIL withdraw_idle got=%b exp=0", bus_granted);
    end
  endtask

  task automatic test_bad_id();
    int bad;
    bad = 0;
    do_reset();
    mslave_id = 9'b000_000_111;
    mreq      = 3'b001;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (mgrant !== 3'b000 || bus_granted !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL bad_id_granted got=%0d bad cycles exp=0", bad);
    end
    mslave_id = {3'd0, 3'd2, 3'd7};
    mreq      = 3'b011;
    tick(5);
    checks++;
    if (mgrant !== 3'b010) begin
      failures++; $display("FAIL bad_id_other got=%b exp=010", mgrant);
    end
  endtask

  task automatic test_timeout();
    int high_cnt;
    int err_cnt;
    high_cnt = 0;
    err_cnt  = 0;
    do_reset();
    mslave_id = 9'b000_000_000;
    mreq      = 3'b001;
    tick(5);
`ifdef BUS_ARB_TIMEOUT_EN
    for (int i = 0; i < 14; i++) begin
      if (mgrant !== 3'b000) high_cnt++;
      if (timeout_err === 1'b1) err_cnt++;
      tick(1);
    end
    checks++;
    if (high_cnt !== 10) begin
      failures++; $display("FAIL timeout_grant_len got=%0d exp=10", high_cnt);
    end
    checks++;
    if (err_cnt !== 1) begin
      failures++; $display("FAIL timeout_err_pulses got=%0d exp=1", err_cnt);
    end
`else
    for (int i = 0; i < 1000; i++) begin
      if (mgrant === 3'b001) high_cnt++;
      if (timeout_err !== 1'b0) err_cnt++;
      tick(1);
    end
    checks++;
    if (high_cnt !== 1000) begin
      failures++; $display("FAIL no_timeout_hold got=%0d exp=1000", high_cnt);
    end
    checks++;
    if (err_cnt !== 0) begin
      failures++; $display("FAIL no_timeout_err got=%0d exp=0", err_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    mslave_id = 9'b000_000_010;
    mreq      = 3'b001;
    tick(2);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (mgrant !== 3'b000 || arbiter_cmd_out !== 1'b0 || bus_granted !== 1'b0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL midrst_outputs got mgrant=%b cmd=%b bg=%b te=%b exp all 0",
               mgrant, arbiter_cmd_out, bus_granted, timeout_err);
    end
    checks++;
    if (cur_master !== 2'd2) begin
      failures++; $display("FAIL midrst_cur got=%0d exp=2", cur_master);
    end
    #1;
    rstn      = 1'b1;
    mslave_id = 9'b000_000_000;
    mreq      = 3'b011;
    tick(5);
    checks++;
    if (mgrant !== 3'b001) begin
      failures++; $display("FAIL midrst_priority got=%b exp=001", mgrant);
    end
  endtask

  initial begin
    rstn       = 1'b0;
    mreq       = '0;
    mslave_id  = '0;
    slave_busy = '0;
    bus_util   = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_busy_skip();
    test_withdraw();
    test_bad_id();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
